ammo_supply: RTL
================

Name: ammo_supply

Overview:
Magazine-side supplier for the weapons block. It holds a reserve ammo stock and, on a reload trigger, transfers rounds from the reserve in fixed-size chunks. It then drives the weapon's ammo load value and loading strobe, and reads the weapon's live ammo count back. It also accepts restock deliveries from the cargo side over a valid/ready handshake.

Parameters:
N, 9, width of weapon ammo bus
RW, 12, width of reserve counter; reserve saturates at 2^RW-1
MAG_CAP, 256, maximum rounds the weapon magazine holds
RESERVE_INIT, 1024, reserve value after reset
CHUNK, 16, maximum rounds moved from reserve per XFER cycle
LOAD_CYCLES, 2, cycles loading_ammo is held high
LOW_MARK, 8, auto-reload threshold (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cur_ammo  in  N  live ammo count from the weapon counter
weapon_error  in  1  weapon error flag (used only with the optional feature)
reload_req  in  1  manual reload request, sampled in IDLE only
restock_valid  in  1  restock delivery valid
restock_qty  in  RW  rounds delivered
restock_ready  out  1  high only in IDLE
ammo_out  out  N  load value presented to the weapon
loading_ammo  out  1  weapon load strobe
reserve  out  RW  current reserve count
busy  out  1  high whenever state != IDLE
empty_err  out  1  sticky flag: reload attempted with empty reserve

Behaviour:
- Reset values on a clk edge with rst=1:
  - state=IDLE, reserve=RESERVE_INIT
  - ammo_out=0, loading_ammo=0, empty_err=0
  - grant=0, staged=0
  - rst overrides every other input.
- Registered outputs:
  - busy = (state!=IDLE)
  - restock_ready = (state==IDLE)
- IDLE:
  - When restock_valid and restock_ready: reserve <= min(reserve+restock_qty, 2^RW-1). The sum is computed at RW+1 bits.
  - trigger=reload_req, plus the auto terms under the optional feature.
  - On trigger, go to CHECK.
  - Restock and trigger in the same cycle: both take effect; CHECK sees the updated reserve.
- CHECK (1 cycle):
  - need = (cur_ammo>=MAG_CAP) ? 0 : MAG_CAP-cur_ammo.
  - If need==0: return to IDLE with no load.
  - Else if reserve==0: set empty_err=1 and return to IDLE.
  - Else: grant=min(need,reserve), staged=0, go to XFER.
- XFER:
  - Each cycle, step=min(CHUNK, grant-staged); reserve -= step; staged += step.
  - When staged reaches grant (the same cycle as the final step), go to LOAD.
  - XFER lasts ceil(grant/CHUNK) cycles.
- LOAD entry:
  - ammo_out = min(MAG_CAP, cur_ammo+grant), using cur_ammo sampled at entry so rounds fired during XFER are accounted for. Compute at N+1 bits.
  - loading_ammo=1 for exactly LOAD_CYCLES cycles, with ammo_out held stable.
  - empty_err clears at LOAD entry.
  - Then return to IDLE with loading_ammo=0; ammo_out keeps its last value.
- Latency: trigger sampled at edge 0 → CHECK at cycle 1 → XFER → loading_ammo first high at cycle 2+ceil(grant/CHUNK).
- reload_req while busy: ignored, not queued.
- restock_valid while busy: not accepted; the source must hold it until ready.
- Reset mid-operation: abort at the next edge. reserve returns to RESERVE_INIT, staged rounds are discarded, loading_ammo drops.
- reserve never underflows, since grant<=reserve. ammo_out never exceeds MAG_CAP.

Optional Feature:
AMMO_AUTO_RELOAD_EN.
- Defined: in IDLE, trigger = reload_req | (cur_ammo<=LOW_MARK) | weapon_error.
  - The auto trigger is suppressed when reserve==0 and empty_err is already 1, so the block does not retrigger every cycle.
- Undefined: trigger = reload_req only; weapon_error and LOW_MARK are unused.

Test Plan:
- Reset → reserve=1024, ammo_out=0, loading_ammo=0, busy=0, restock_ready=1 (after first edge), empty_err=0.
- cur_ammo=200, reload_req pulse → grant=56:
  - XFER steps 16,16,16,8 (4 cycles), reserve=968.
  - Then ammo_out=256 and loading_ammo=1 for 2 cycles, then IDLE.
- RESERVE_INIT=20, cur_ammo=0:
  - Reload → ammo_out=20, reserve=0.
  - Second reload → empty_err=1, no loading_ammo.
  - Restock qty=100 then reload (cur_ammo=20) → grant=100, ammo_out=120, empty_err cleared.
- Reserve saturation: reserve=4000, restock qty=200 in IDLE → reserve=4095.
  - restock_valid during XFER → ready=0, accepted only on the first IDLE cycle.
- cur_ammo=256, reload_req → CHECK then IDLE, reserve unchanged, no strobe.
- rst asserted during 2nd XFER cycle → next cycle state IDLE, reserve=1024, loading_ammo=0.
  - With AMMO_AUTO_RELOAD_EN: cur_ammo=5 and no request → reload starts automatically.

Source files
------------

// File: rtl/ammo_supply_if.sv
// rtl/ammo_supply_if.sv - weapon-side and restock signal bundle for ammo_supply
interface ammo_supply_if #(
  parameter int N  = 9,
  parameter int RW = 12
) ();
  logic [N-1:0]  cur_ammo;
  logic          weapon_error;
  logic          reload_req;
  logic          restock_valid;
  logic [RW-1:0] restock_qty;
  logic          restock_ready;
  logic [N-1:0]  ammo_out;
  logic          loading_ammo;
  logic [RW-1:0] reserve;
  logic          busy;
  logic          empty_err;

  modport master (
    output cur_ammo, weapon_error, reload_req, restock_valid, restock_qty,
    input  restock_ready, ammo_out, loading_ammo, reserve, busy, empty_err
  );

  modport slave (
    input  cur_ammo, weapon_error, reload_req, restock_valid, restock_qty,
    output restock_ready, ammo_out, loading_ammo, reserve, busy, empty_err
  );
endinterface

// File: rtl/ammo_supply.sv
// rtl/ammo_supply.sv - reserve stock, chunked reload transfer and weapon load strobe
// Optional auto-reload on low ammo / weapon error: define AMMO_AUTO_RELOAD_EN.
module ammo_supply #(
  parameter int N            = 9,
  parameter int RW           = 12,
  parameter int MAG_CAP      = 256,
  parameter int RESERVE_INIT = 1024,
  parameter int CHUNK        = 16,
  parameter int LOAD_CYCLES  = 2,
  parameter int LOW_MARK     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ammo_supply_if.slave bus
);
  localparam int GW = N + 1;
  localparam int CW = (RW > GW) ? RW : GW;
  localparam logic [RW-1:0] RES_MAX   = {RW{1'b1}};
  localparam logic [GW-1:0] CAP       = GW'(MAG_CAP);
  localparam logic [GW-1:0] CHUNK_W   = GW'(CHUNK);
  localparam logic [7:0]    LOAD_LAST = 8'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, XFER, LOAD} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] reserve_q, reserve_nx;
  logic [N-1:0]  ammo_q, ammo_nx;
  logic          loading_q, loading_nx;
  logic          empty_q, empty_nx;
  logic [GW-1:0] grant_q, grant_nx;
  logic [GW-1:0] staged_q, staged_nx;
  logic [7:0]    load_cnt_q, load_cnt_nx;
  logic          ready_q, busy_q;

  logic          trigger;
  logic [RW:0]   restock_sum;
  logic [GW-1:0] cur_w, need, remain, step, load_sum;

`ifdef AMMO_AUTO_RELOAD_EN
  logic auto_hit;
  assign auto_hit = (bus.cur_ammo <= N'(LOW_MARK)) || bus.weapon_error;
  // An empty reserve that has already been flagged must not retrigger every cycle.
  assign trigger  = bus.reload_req || (auto_hit && !((reserve_q == '0) && empty_q));
`else
  localparam int unused_low_mark = LOW_MARK;
  logic unused_weapon_error;
  assign unused_weapon_error = bus.weapon_error;
  assign trigger = bus.reload_req;
`endif

  always_comb begin
    state_nx    = state;
    reserve_nx  = reserve_q;
    ammo_nx     = ammo_q;
    loading_nx  = loading_q;
    empty_nx    = empty_q;
    grant_nx    = grant_q;
    staged_nx   = staged_q;
    load_cnt_nx = load_cnt_q;

    cur_w       = {1'b0, bus.cur_ammo};
    restock_sum = {1'b0, reserve_q} + {1'b0, bus.restock_qty};
    need        = (cur_w >= CAP) ? '0 : CAP - cur_w;
    remain      = grant_q - staged_q;
    step        = (remain > CHUNK_W) ? CHUNK_W : remain;
    load_sum    = cur_w + grant_q;

    case (state)
      IDLE: begin
        if (bus.restock_valid && ready_q)
          reserve_nx = restock_sum[RW] ? RES_MAX : restock_sum[RW-1:0];
        if (trigger)
          state_nx = CHECK;
      end
      CHECK: begin
        if (need == '0) begin
          state_nx = IDLE;
        end else if (reserve_q == '0) begin
          empty_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          grant_nx  = (CW'(reserve_q) < CW'(need)) ? GW'(reserve_q) : need;
          staged_nx = '0;
          state_nx  = XFER;
        end
      end
      XFER: begin
        reserve_nx = reserve_q - RW'(step);
        staged_nx  = staged_q + step;
        // cur_ammo is sampled here so rounds fired during the transfer are counted.
        if ((staged_q + step) == grant_q) begin
          state_nx    = LOAD;
          ammo_nx     = (load_sum > CAP) ? N'(CAP) : load_sum[N-1:0];
          loading_nx  = 1'b1;
          empty_nx    = 1'b0;
          load_cnt_nx = '0;
        end
      end
      LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          loading_nx = 1'b0;
          state_nx   = IDLE;
        end else begin
          load_cnt_nx = load_cnt_q + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reserve_q  <= RW'(RESERVE_INIT);
      ammo_q     <= '0;
      loading_q  <= 1'b0;
      empty_q    <= 1'b0;
      grant_q    <= '0;
      staged_q   <= '0;
      load_cnt_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      reserve_q  <= reserve_nx;
      ammo_q     <= ammo_nx;
      loading_q  <= loading_nx;
      empty_q    <= empty_nx;
      grant_q    <= grant_nx;
      staged_q   <= staged_nx;
      load_cnt_q <= load_cnt_nx;
      ready_q    <= (state_nx == IDLE);
      busy_q     <= (state_nx != IDLE);
    end
  end

  assign bus.restock_ready = ready_q;
  assign bus.busy          = busy_q;
  assign bus.ammo_out      = ammo_q;
  assign bus.loading_ammo  = loading_q;
  assign bus.reserve       = reserve_q;
  assign bus.empty_err     = empty_q;
endmodule
